// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: state encodings and
// architectural register indices used by the register file.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_MEM_WAIT = 2'd1,
        WB_WB       = 2'd2
    } wb_state_t;

    localparam logic [3:0] REG0 = 4'd0;
    localparam logic [3:0] T    = 4'd14;
    localparam logic [3:0] PC   = 4'd15;

endpackage

// File: rtl/writeback_stage_timer.sv
// Memory-access watchdog: counts stalled request cycles and flags the
// cycle in which the count has reached MEM_TIMEOUT-1.
module wb_timeout_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    input  logic Enable,
    output logic Expire
);

    logic [15:0] count;

    always_ff @(posedge Clk) begin
        if (Rst || Clear)
            count <= '0;
        else if (Enable)
            count <= count + 16'd1;
    end

    assign Expire = (count == 16'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/writeback_stage.sv
// Memory/writeback stage: retires ALU results directly or after a single
// req/ack data-memory access, driving the register-file write port.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ExValid,
    output logic             ExReady,
    input  logic [15:0]      ExAluResult,
    input  logic [15:0]      ExStoreData,
    input  logic [3:0]       ExDestReg,
    input  logic             ExRegWrite,
    input  logic             ExMemRead,
    input  logic             ExMemWrite,
    output logic             MemReq,
    output logic             MemWe,
    output logic [15:0]      MemAddr,
    output logic [15:0]      MemWData,
    input  logic [15:0]      MemRData,
    input  logic             MemAck,
    output logic             RegWre,
    output logic [3:0]       WriteReg,
    output logic [15:0]      WriteData,
    output logic             Fault,
    output logic [CNT_W-1:0] RetireCount
);

    wb_state_t  state;
    logic [3:0] dest_q;
    logic       regwrite_q;
    logic       expire;
    logic       timer_clear;

    assign ExReady     = !Rst && (state == WB_IDLE || state == WB_WB);
    // The count only runs while waiting; any exit from MEM_WAIT restarts it.
    assign timer_clear = (state != WB_MEM_WAIT) || MemAck || expire;

    wb_timeout_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clear  (timer_clear),
        .Enable (MemReq && !MemAck),
        .Expire (expire)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= WB_IDLE;
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            RegWre      <= 1'b0;
            WriteReg    <= '0;
            WriteData   <= '0;
            Fault       <= 1'b0;
            RetireCount <= '0;
            dest_q      <= '0;
            regwrite_q  <= 1'b0;
        end else begin
            RegWre <= 1'b0;
            Fault  <= 1'b0;
            case (state)
                WB_IDLE, WB_WB: begin
                    state <= WB_IDLE;
                    if (ExValid) begin
                        if (ExMemRead && ExMemWrite) begin
                            Fault <= 1'b1;
                        end else if (ExMemRead || ExMemWrite) begin
                            state      <= WB_MEM_WAIT;
                            MemReq     <= 1'b1;
                            MemWe      <= ExMemWrite;
                            MemAddr    <= ExAluResult;
                            MemWData   <= ExStoreData;
                            dest_q     <= ExDestReg;
                            regwrite_q <= ExRegWrite;
                        end else begin
                            state       <= WB_WB;
                            RegWre      <= ExRegWrite && (ExDestReg != REG0);
                            WriteReg    <= ExDestReg;
                            WriteData   <= ExAluResult;
                            RetireCount <= RetireCount + CNT_W'(1);
                        end
                    end
                end
                WB_MEM_WAIT: begin
                    // Ack is checked first so a completion coinciding with expiry wins.
                    if (MemAck) begin
                        MemReq      <= 1'b0;
                        RetireCount <= RetireCount + CNT_W'(1);
                        if (MemWe) begin
                            state <= WB_IDLE;
                        end else begin
                            state     <= WB_WB;
                            RegWre    <= regwrite_q && (dest_q != REG0);
                            WriteReg  <= dest_q;
                            WriteData <= MemRData;
                        end
                    end else if (expire) begin
                        MemReq <= 1'b0;
                        Fault  <= 1'b1;
                        state  <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: ALU vector table, directed
// memory/timeout/reset/illegal sequences, then randomized traffic vs a model.
module tb_writeback_stage;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          ExValid;
    logic          ExReady;
    logic [15:0]   ExAluResult;
    logic [15:0]   ExStoreData;
    logic [3:0]    ExDestReg;
    logic          ExRegWrite;
    logic          ExMemRead;
    logic          ExMemWrite;
    logic          MemReq;
    logic          MemWe;
    logic [15:0]   MemAddr;
    logic [15:0]   MemWData;
    logic [15:0]   MemRData;
    logic          MemAck;
    logic          RegWre;
    logic [3:0]    WriteReg;
    logic [15:0]   WriteData;
    logic          Fault;
    logic [CW-1:0] RetireCount;

    writeback_stage #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst),
        .ExValid(ExValid), .ExReady(ExReady),
        .ExAluResult(ExAluResult), .ExStoreData(ExStoreData),
        .ExDestReg(ExDestReg), .ExRegWrite(ExRegWrite),
        .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
        .Fault(Fault), .RetireCount(RetireCount)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs;
        ExValid = 0; ExAluResult = '0; ExStoreData = '0; ExDestReg = '0;
        ExRegWrite = 0; ExMemRead = 0; ExMemWrite = 0; MemAck = 0; MemRData = '0;
    endtask

    task automatic do_reset;
        Rst = 1; idle_inputs();
        step(); step();
        Rst = 0;
    endtask

    task automatic drive_op(input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] d,
                            input logic rw, input logic rd, input logic wr);
        ExValid = 1; ExAluResult = alu; ExStoreData = sd; ExDestReg = d;
        ExRegWrite = rw; ExMemRead = rd; ExMemWrite = wr;
    endtask

    typedef struct {
        logic          v;
        logic [15:0]   alu;
        logic [3:0]    dest;
        logic          rw;
        logic          e_wre;
        logic [3:0]    e_reg;
        logic [15:0]   e_data;
        logic [CW-1:0] e_ret;
    } alu_vec_t;

    alu_vec_t tbl[6];

    // randomized-phase model state
    logic          mem_active;
    int            mem_cycles;
    int            mem_delay;
    logic          cur_we;
    logic [15:0]   cur_addr;
    logic [15:0]   cur_wdata;
    logic [3:0]    cur_dest;
    logic          cur_rw;
    logic          exp_wre;
    logic [3:0]    exp_reg;
    logic [15:0]   exp_data;
    logic          exp_fault;
    logic [CW-1:0] ret_model;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1; idle_inputs();
        step();
        chk("ready_in_reset", ExReady, 0);
        step();
        chk("rst_memreq", MemReq, 0);
        chk("rst_regwre", RegWre, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_retire", RetireCount, 0);
        chk("rst_writedata", WriteData, 0);
        Rst = 0;
        #1;
        chk("ready_after_rst", ExReady, 1);

        // ALU vector table: expectations apply to the cycle after each drive
        tbl[0] = '{1, 16'h1234, 4'd3,  1, 1, 4'd3,  16'h1234, 1};
        tbl[1] = '{1, 16'h00FF, 4'd5,  1, 1, 4'd5,  16'h00FF, 2};
        tbl[2] = '{1, 16'hABCD, 4'd0,  1, 0, 4'd0,  16'h0000, 3};
        tbl[3] = '{1, 16'h5555, 4'd9,  0, 0, 4'd0,  16'h0000, 4};
        tbl[4] = '{0, 16'h7777, 4'd6,  1, 0, 4'd0,  16'h0000, 4};
        tbl[5] = '{1, 16'hFFFF, 4'd15, 1, 1, 4'd15, 16'hFFFF, 5};
        for (int i = 0; i < 6; i++) begin
            chk("tbl_ready", ExReady, 1);
            drive_op(tbl[i].alu, 16'h0, tbl[i].dest, tbl[i].rw, 0, 0);
            ExValid = tbl[i].v;
            step();
            chk("tbl_regwre", RegWre, tbl[i].e_wre);
            if (tbl[i].e_wre) begin
                chk("tbl_writereg", WriteReg, tbl[i].e_reg);
                chk("tbl_writedata", WriteData, tbl[i].e_data);
            end
            chk("tbl_retire", RetireCount, tbl[i].e_ret);
        end
        idle_inputs();
        step();
        chk("wb_to_idle_regwre", RegWre, 0);

        // load, ack in the third request cycle
        drive_op(16'h0040, 16'h0, 4'd7, 1, 1, 0);
        step();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            chk("ld_memreq", MemReq, 1);
            chk("ld_memaddr", MemAddr, 16'h0040);
            chk("ld_memwe", MemWe, 0);
            chk("ld_ready", ExReady, 0);
            chk("ld_no_wre", RegWre, 0);
            if (k == 3) begin MemAck = 1; MemRData = 16'hBEEF; end
            step();
        end
        MemAck = 0; MemRData = '0;
        chk("ld_wre", RegWre, 1);
        chk("ld_reg", WriteReg, 7);
        chk("ld_data", WriteData, 16'hBEEF);
        chk("ld_req_drop", MemReq, 0);
        chk("ld_retire", RetireCount, 6);
        step();
        chk("ld_wre_once", RegWre, 0);

        // store, immediate ack
        drive_op(16'h0010, 16'hA5A5, 4'd2, 0, 0, 1);
        step();
        idle_inputs();
        chk("st_memreq", MemReq, 1);
        chk("st_memwe", MemWe, 1);
        chk("st_addr", MemAddr, 16'h0010);
        chk("st_wdata", MemWData, 16'hA5A5);
        MemAck = 1;
        step();
        MemAck = 0;
        chk("st_req_drop", MemReq, 0);
        chk("st_no_wre", RegWre, 0);
        chk("st_retire", RetireCount, 7);
        chk("st_ready", ExReady, 1);

        // load that never gets acked
        drive_op(16'h0123, 16'h0, 4'd4, 1, 1, 0);
        step();
        idle_inputs();
        for (int k = 1; k <= int'(TO); k++) begin
            chk("to_memreq", MemReq, 1);
            chk("to_no_fault", Fault, 0);
            step();
        end
        chk("to_req_drop", MemReq, 0);
        chk("to_fault", Fault, 1);
        chk("to_no_wre", RegWre, 0);
        chk("to_ready", ExReady, 1);
        chk("to_retire", RetireCount, 7);
        step();
        chk("to_fault_pulse", Fault, 0);

        // reset in the middle of an access, late ack afterwards
        drive_op(16'h0300, 16'h0, 4'd8, 1, 1, 0);
        step();
        idle_inputs();
        step();
        chk("mr_memreq_before", MemReq, 1);
        Rst = 1;
        step();
        chk("mr_memreq", MemReq, 0);
        chk("mr_memaddr", MemAddr, 0);
        chk("mr_retire", RetireCount, 0);
        chk("mr_writereg", WriteReg, 0);
        chk("mr_ready", ExReady, 0);
        Rst = 0;
        MemAck = 1; MemRData = 16'h1111;
        step();
        MemAck = 0;
        chk("mr_late_ack_wre", RegWre, 0);
        chk("mr_late_ack_req", MemReq, 0);
        chk("mr_late_ack_retire", RetireCount, 0);
        step();
        chk("mr_late_ack_wre2", RegWre, 0);

        // illegal read+write
        drive_op(16'h0050, 16'h9999, 4'd3, 1, 1, 1);
        step();
        idle_inputs();
        chk("ill_fault", Fault, 1);
        chk("ill_memreq", MemReq, 0);
        chk("ill_wre", RegWre, 0);
        chk("ill_retire", RetireCount, 0);
        step();
        chk("ill_fault_pulse", Fault, 0);
        chk("ill_memreq2", MemReq, 0);

        // randomized traffic against a transaction-level model
        do_reset();
        mem_active = 0; mem_cycles = 0; mem_delay = 0;
        cur_we = 0; cur_addr = '0; cur_wdata = '0; cur_dest = '0; cur_rw = 0;
        exp_wre = 0; exp_reg = '0; exp_data = '0; exp_fault = 0; ret_model = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step();
            chk("rnd_regwre", RegWre, exp_wre);
            if (exp_wre) begin
                chk("rnd_writereg", WriteReg, exp_reg);
                chk("rnd_writedata", WriteData, exp_data);
            end
            chk("rnd_fault", Fault, exp_fault);
            chk("rnd_retire", RetireCount, ret_model);
            chk("rnd_ready", ExReady, !mem_active);
            chk("rnd_memreq", MemReq, mem_active);
            if (mem_active) begin
                chk("rnd_memaddr", MemAddr, cur_addr);
                chk("rnd_memwe", MemWe, cur_we);
                if (cur_we) chk("rnd_memwdata", MemWData, cur_wdata);
            end

            idle_inputs();
            exp_wre = 0; exp_fault = 0;
            if (mem_active) begin
                mem_cycles++;
                if (mem_cycles == mem_delay) begin
                    MemAck = 1; MemRData = 16'($urandom);
                    ret_model = ret_model + 1'b1;
                    if (!cur_we && cur_rw && cur_dest != 4'd0) begin
                        exp_wre = 1; exp_reg = cur_dest; exp_data = MemRData;
                    end
                    mem_active = 0;
                end else if (mem_cycles == int'(TO)) begin
                    exp_fault = 1;
                    mem_active = 0;
                end
            end else begin
                MemAck = ($urandom_range(0, 7) == 0);
                MemRData = 16'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    int kind;
                    kind = $urandom_range(0, 9);
                    drive_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                             1'($urandom_range(0, 1)), kind == 0 || (kind >= 1 && kind <= 2),
                             kind == 0 || (kind >= 3 && kind <= 4));
                    if (kind == 0) begin
                        exp_fault = 1;
                    end else if (kind <= 4) begin
                        mem_active = 1; mem_cycles = 0;
                        mem_delay = $urandom_range(1, TO + 2);
                        cur_we = ExMemWrite; cur_addr = ExAluResult; cur_wdata = ExStoreData;
                        cur_dest = ExDestReg; cur_rw = ExRegWrite;
                    end else begin
                        ret_model = ret_model + 1'b1;
                        exp_wre = ExRegWrite && (ExDestReg != 4'd0);
                        exp_reg = ExDestReg; exp_data = ExAluResult;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
